// File: rtl/compuertas_checker.sv
// -----------------------------------------------------------------------------
// compuertas_checker
//
// Self-test sequencer and response checker for the three-input / two-output
// gate block. On start it walks A/B/C through vectors 000..111, holding each
// one for DWELL cycles. On the last cycle of each dwell it compares S1/S2
// against the golden truth tables and accumulates the mismatch count, a
// per-vector fail mask and (optionally) the index of the first failing vector.
//
// Parameters:
//   DWELL   cycles each vector is held (1..255)
//   EXP_S1  golden S1, bit i = expected S1 for vector i = {A,B,C}
//   EXP_S2  golden S2, same indexing
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               run request, honoured in IDLE or DONE only
//   s1_in, s2_in        responses from the gate block (synchronous to clk)
//   a_out, b_out, c_out stimulus to the gate block (vector bits 2, 1, 0)
//   busy                high while vectors are being applied
//   done                high once a run has completed, until the next start
//   pass                done and no mismatches
//   err_count           total output mismatches of the run (0..16)
//   fail_mask           bit i set if vector i mismatched on S1 or S2
//   first_fail          [3] valid, [2:0] index of the first failing vector
//
// Build option:
//   CHK_FIRST_FAIL_EN   when defined, first_fail captures the first failing
//                       vector; otherwise it is tied to 4'b0000.
// -----------------------------------------------------------------------------
module compuertas_checker #(
  parameter int unsigned DWELL  = 4,
  parameter logic [7:0]  EXP_S1 = 8'b1000_0000,
  parameter logic [7:0]  EXP_S2 = 8'b1111_1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s1_in,
  input  logic       s2_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [7:0] fail_mask,
  output logic [3:0] first_fail
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic [7:0] mask_q, mask_d;

  logic       sample;
  logic       mis_s1;
  logic       mis_s2;
  logic       vec_fail;
  logic       run_start;

  // Sample point: last cycle of the current vector's dwell.
  always_comb begin
    sample    = (state_q == ST_APPLY) && (cnt_q == CNT_LAST);
    mis_s1    = (s1_in != EXP_S1[idx_q]);
    mis_s2    = (s2_in != EXP_S2[idx_q]);
    vec_fail  = mis_s1 || mis_s2;
    run_start = start && (state_q != ST_APPLY);
  end

  // Next-state and result update. The vector index wraps from 7 back to 0
  // on the final sample, so the stimulus returns to 000 in DONE without a
  // separate clear.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mask_d  = mask_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_APPLY;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          err_d   = 5'd0;
          mask_d  = 8'd0;
        end
      end
      ST_APPLY: begin
        if (sample) begin
          cnt_d = 8'd0;
          idx_d = idx_q + 3'd1;
          err_d = err_q + 5'(mis_s1) + 5'(mis_s2);
          if (vec_fail) begin
            mask_d[idx_q] = 1'b1;
          end
          if (idx_q == 3'd7) begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= 5'd0;
      mask_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

`ifdef CHK_FIRST_FAIL_EN
  logic [3:0] ff_q, ff_d;

  // Only the first failing vector of a run is kept; the valid bit blocks
  // later overwrites.
  always_comb begin
    ff_d = ff_q;
    if (run_start) begin
      ff_d = 4'd0;
    end else if (sample && vec_fail && !ff_q[3]) begin
      ff_d = {1'b1, idx_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= 4'd0;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign first_fail = ff_q;
`else
  logic unused_run_start;
  assign unused_run_start = run_start;
  assign first_fail       = 4'b0000;
`endif

  // Outputs are decoded directly from registered state.
  assign a_out     = idx_q[2];
  assign b_out     = idx_q[1];
  assign c_out     = idx_q[0];
  assign busy      = (state_q == ST_APPLY);
  assign done      = (state_q == ST_DONE);
  assign pass      = (state_q == ST_DONE) && (err_q == 5'd0);
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_compuertas_checker.sv
module tb_compuertas_checker;

  localparam int DW0 = 4;
  localparam int DW1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  int         mode;

  logic       a0, b0, c0, busy0, done0, pass0;
  logic [4:0] err0;
  logic [7:0] mask0;
  logic [3:0] ff0;
  logic       s1_0, s2_0;

  logic       a1, b1, c1, busy1, done1, pass1;
  logic [4:0] err1;
  logic [7:0] mask1;
  logic [3:0] ff1;
  logic       s1_1, s2_1;

  // Gate block model: ideal S1 = A&B&C, S2 = A|B|C, with fault modes.
  //   mode 0: ideal, mode 1: S2 stuck at 0, mode 2: both outputs inverted
  always_comb begin
    s1_0 = a0 & b0 & c0;
    s2_0 = a0 | b0 | c0;
    if (mode == 1) s2_0 = 1'b0;
    if (mode == 2) begin
      s1_0 = ~(a0 & b0 & c0);
      s2_0 = ~(a0 | b0 | c0);
    end
  end

  assign s1_1 = a1 & b1 & c1;
  assign s2_1 = a1 | b1 | c1;

  compuertas_checker #(.DWELL(DW0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .s1_in(s1_0), .s2_in(s2_0),
    .a_out(a0), .b_out(b0), .c_out(c0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_mask(mask0), .first_fail(ff0)
  );

  compuertas_checker #(.DWELL(DW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s1_in(s1_1), .s2_in(s2_1),
    .a_out(a1), .b_out(b1), .c_out(c1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_mask(mask1), .first_fail(ff1)
  );

  typedef struct {
    int err;
    int mask;
    int ff;
    int pass;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Expected results for a full run under a given gate fault mode.
  function automatic exp_t model(input int m);
    exp_t e;
    e.err = 0; e.mask = 0; e.ff = 0;
    for (int v = 0; v < 8; v++) begin
      logic va, vb, vc, g1, g2, r1, r2;
      int   n;
      va = v[2]; vb = v[1]; vc = v[0];
      g1 = va & vb & vc;
      g2 = va | vb | vc;
      r1 = g1; r2 = g2;
      if (m == 1) r2 = 1'b0;
      if (m == 2) begin r1 = ~g1; r2 = ~g2; end
      n = int'(r1 != g1) + int'(r2 != g2);
      e.err += n;
      if (n != 0) begin
        e.mask |= (1 << v);
`ifdef CHK_FIRST_FAIL_EN
        if (e.ff == 0) e.ff = 8 + v;
`endif
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  // One run on the DWELL=4 instance. restart_at: cycle index at which start
  // is re-pulsed mid-run (-1 none). abort_at: cycle index at which reset is
  // asserted (-1 none). Checks busy and abc on every cycle of the run.
  task automatic run0(input int m, input int restart_at, input int abort_at);
    exp_t e;
    mode = m;
    exp_q.push_back(model(m));
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int k = 0; k < 8 * DW0; k++) begin
      chk("busy_during_run", int'(busy0), 1);
      chk("abc_vector", int'({a0, b0, c0}), k / DW0);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy0), 0);
        chk("rst_abc", int'({a0, b0, c0}), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_err", int'(err0), 0);
        chk("rst_mask", int'(mask0), 0);
        chk("rst_ff", int'(ff0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle_busy", int'(busy0), 0);
        chk("post_rst_idle_done", int'(done0), 0);
        void'(exp_q.pop_front());
        return;
      end
      start0 = (k == restart_at) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    chk("busy_fell", int'(busy0), 0);
    chk("done_rose", int'(done0), 1);
    chk("abc_back_to_0", int'({a0, b0, c0}), 0);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("pass", int'(pass0), e.pass);
      chk("err_count", int'(err0), e.err);
      chk("fail_mask", int'(mask0), e.mask);
      chk("first_fail", int'(ff0), e.ff);
    end
    // Results must hold stable in DONE.
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", int'(done0), 1);
    if (e.err >= 0) chk("err_held", int'(err0), e.err);
  endtask

  initial begin
    int cyc;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy0), 0);
    chk("reset_done", int'(done0), 0);
    chk("reset_pass", int'(pass0), 0);
    chk("reset_err", int'(err0), 0);
    chk("reset_mask", int'(mask0), 0);
    chk("reset_ff", int'(ff0), 0);
    chk("reset_abc", int'({a0, b0, c0}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run0(0, -1, -1);     // ideal gates
    run0(1, -1, -1);     // S2 stuck at 0, started from DONE
    run0(2, -1, -1);     // both outputs inverted
    run0(0, 13, -1);     // start re-pulsed during vector 3
    run0(1, -1, -1);     // start in DONE clears and reruns
    run0(0, -1, 21);     // reset during vector 5
    run0(0, -1, -1);     // full run after reset

    // DWELL=1 instance: new vector every cycle, busy exactly 8 cycles.
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 0;
    while (busy1 && cyc < 20) begin
      chk("dw1_abc", int'({a1, b1, c1}), cyc);
      cyc++;
      @(posedge clk); #1;
    end
    chk("dw1_busy_cycles", cyc, 8);
    chk("dw1_done", int'(done1), 1);
    chk("dw1_pass", int'(pass1), 1);
    chk("dw1_err", int'(err1), 0);
    chk("dw1_mask", int'(mask1), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
